// File: rtl/ntt_stage_addr_gen.sv
// Address and control sequencer for an in-place Cooley-Tukey NTT.
// Issues one butterfly per cycle and drains the pipeline between stages.
module ntt_stage_addr_gen #(
  parameter int N          = 256,
  parameter int LOG_N      = 8,
  parameter int ADDR_W     = 8,
  parameter int PIPE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [ADDR_W-1:0] tw_addr,
  output logic [ADDR_W-1:0] stage_o,
  output logic              valid_o,
  output logic              busy,
  output logic              done
);

  localparam int                 DRAIN_W = $clog2(PIPE_DEPTH) + 1;
  localparam logic [ADDR_W-1:0]  J_LAST  = ADDR_W'(N / 2 - 1);
  localparam logic [ADDR_W-1:0]  S_LAST  = ADDR_W'(LOG_N - 1);
  localparam logic [ADDR_W-1:0]  LOG_N_W = ADDR_W'(LOG_N);
  localparam logic [DRAIN_W-1:0] D_LAST  = DRAIN_W'(PIPE_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  s_q, s_d;
  logic [ADDR_W-1:0]  j_q, j_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic [ADDR_W-1:0]  len;
  logic [ADDR_W-1:0]  group;
  logic [ADDR_W-1:0]  k;
  logic [ADDR_W-1:0]  base_a;
  logic [ADDR_W-1:0]  tw;
  logic               run;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      j_q     <= j_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        if (!stall) begin
          if (j_q == J_LAST) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Drain ignores stall: only in-flight write-backs matter here.
        if (drain_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + 1'b1;
            j_d     = '0;
          end
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
        j_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // group*2*len is group shifted by (LOG_N - s); group < 2^s so it never overflows.
  always_comb begin
    len    = ADDR_W'(N >> (s_q + 1));
    group  = j_q >> (S_LAST - s_q);
    k      = j_q & (len - 1'b1);
    base_a = (group << (LOG_N_W - s_q)) | k;
    tw     = (ADDR_W'(1) << s_q) + group;
  end

  always_comb begin
    run     = (state_q == RUN);
    addr_a  = run ? base_a : '0;
    addr_b  = run ? (base_a + len) : '0;
    tw_addr = run ? tw : '0;
    stage_o = s_q;
    valid_o = run && !stall;
    busy    = run || (state_q == DRAIN);
    done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_ntt_stage_addr_gen.sv
// Directed bench for ntt_stage_addr_gen: a small N=8 instance checked against a
// butterfly scoreboard, plus an N=256 instance checked for count, latency and last butterfly.
module tb_ntt_stage_addr_gen;

  localparam int SN   = 8;
  localparam int SLOG = 3;
  localparam int SW   = 3;
  localparam int SP   = 3;
  localparam int BN   = 256;
  localparam int BLOG = 8;
  localparam int BW   = 8;
  localparam int BP   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sReset, sStart, sStall;
  logic [SW-1:0] sA, sB, sTw, sStage;
  logic          sValid, sBusy, sDone;

  logic          bReset, bStart, bStall;
  logic [BW-1:0] bA, bB, bTw, bStage;
  logic          bValid, bBusy, bDone;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int a;
    int b;
    int tw;
    int st;
  } bfly_t;

  bfly_t sq[$];
  int    lastStage;
  int    gapCnt;

  ntt_stage_addr_gen #(.N(SN), .LOG_N(SLOG), .ADDR_W(SW), .PIPE_DEPTH(SP)) dutSmall (
    .clk(clk), .reset(sReset), .start(sStart), .stall(sStall),
    .addr_a(sA), .addr_b(sB), .tw_addr(sTw), .stage_o(sStage),
    .valid_o(sValid), .busy(sBusy), .done(sDone)
  );

  ntt_stage_addr_gen #(.N(BN), .LOG_N(BLOG), .ADDR_W(BW), .PIPE_DEPTH(BP)) dutBig (
    .clk(clk), .reset(bReset), .start(bStart), .stall(bStall),
    .addr_a(bA), .addr_b(bB), .tw_addr(bTw), .stage_o(bStage),
    .valid_o(bValid), .busy(bBusy), .done(bDone)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference butterfly order: groups outer, offsets inner, within each stage.
  task automatic pushModel();
    for (int s = 0; s < SLOG; s++) begin
      int len;
      len = SN >> (s + 1);
      for (int g = 0; g < (1 << s); g++) begin
        for (int k = 0; k < len; k++) begin
          bfly_t e;
          e.a  = 2 * len * g + k;
          e.b  = e.a + len;
          e.tw = (1 << s) + g;
          e.st = s;
          sq.push_back(e);
        end
      end
    end
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    sStart = 1'b1;
    @(posedge clk);
    #1;
    sStart = 1'b0;
  endtask

  task automatic checkOutput();
    bfly_t e;
    if (sValid === 1'b1) begin
      checkValue("sb_nonempty", (sq.size() > 0), 1);
      if (sq.size() > 0) begin
        e = sq.pop_front();
        checkValue("addr_a", sA, e.a);
        checkValue("addr_b", sB, e.b);
        checkValue("tw_addr", sTw, e.tw);
        checkValue("stage_o", sStage, e.st);
        if ((sStage != lastStage) && (sStage != 0)) begin
          checkValue("stage_step", sStage, lastStage + 1);
          checkValue("stage_gap", gapCnt, SP);
        end
      end
      lastStage = sStage;
      gapCnt    = 0;
    end else if (sBusy === 1'b1) begin
      gapCnt++;
    end
  endtask

  task automatic runSmall(input int stallCyc, input bit spam, output int doneCyc);
    doneCyc   = -1;
    lastStage = 0;
    gapCnt    = 0;
    pushModel();
    applyStimulus();
    for (int n = 1; n <= 200 && doneCyc < 0; n++) begin
      sStall = (stallCyc > 0) && ((n == stallCyc) || (n == stallCyc + 1));
      sStart = spam && (n % 5 == 0);
      @(negedge clk);
      checkOutput();
      if (sStall) begin
        checkValue("stall_addr_a", sA, 1);
        checkValue("stall_addr_b", sB, 3);
        checkValue("stall_valid", sValid, 0);
      end
      if (sDone === 1'b1) doneCyc = n;
      @(posedge clk);
      #1;
    end
    sStall = 1'b0;
    sStart = 1'b0;
    checkValue("sb_empty", sq.size(), 0);
    @(negedge clk);
    checkValue("done_one_cycle", sDone, 0);
    checkValue("idle_busy", sBusy, 0);
  endtask

  initial begin
    int doneCyc;
    int vCnt;
    logic [BW-1:0] lastA, lastB, lastTw;

    sReset = 1'b0; sStart = 1'b0; sStall = 1'b0;
    bReset = 1'b0; bStart = 1'b0; bStall = 1'b0;
    repeat (2) @(negedge clk);
    checkValue("rst_addr_a", sA, 0);
    checkValue("rst_addr_b", sB, 0);
    checkValue("rst_tw", sTw, 0);
    checkValue("rst_stage", sStage, 0);
    checkValue("rst_valid", sValid, 0);
    checkValue("rst_busy", sBusy, 0);
    checkValue("rst_done", sDone, 0);
    sReset = 1'b1;
    bReset = 1'b1;
    @(negedge clk);

    $display("[TB] N=8 plain transform");
    runSmall(0, 1'b0, doneCyc);
    checkValue("done_cycle_plain", doneCyc, 22);

    $display("[TB] N=8 with two stall cycles at stage 1 j=1");
    runSmall(9, 1'b0, doneCyc);
    checkValue("done_cycle_stall", doneCyc, 24);

    $display("[TB] N=8 with start pulses while busy");
    runSmall(0, 1'b1, doneCyc);
    checkValue("done_cycle_spam", doneCyc, 22);

    $display("[TB] N=8 reset during stage 1 drain");
    lastStage = 0;
    gapCnt    = 0;
    pushModel();
    applyStimulus();
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checkOutput();
      checkValue("abort_no_done_pre", sDone, 0);
      @(posedge clk);
      #1;
    end
    checkValue("abort_in_drain", {sBusy, sValid}, 2'b10);
    sReset = 1'b0;
    #1;
    checkValue("abort_addr_a", sA, 0);
    checkValue("abort_addr_b", sB, 0);
    checkValue("abort_tw", sTw, 0);
    checkValue("abort_stage", sStage, 0);
    checkValue("abort_valid", sValid, 0);
    checkValue("abort_busy", sBusy, 0);
    checkValue("abort_done", sDone, 0);
    checkValue("abort_remaining", sq.size(), 4);
    sq.delete();
    repeat (3) begin
      @(negedge clk);
      checkValue("abort_no_done", sDone, 0);
    end
    sReset = 1'b1;
    @(negedge clk);
    checkValue("abort_idle_done", sDone, 0);
    runSmall(0, 1'b0, doneCyc);
    checkValue("done_cycle_after_abort", doneCyc, 22);

    $display("[TB] N=256 full transform");
    vCnt    = 0;
    doneCyc = -1;
    lastA   = '0;
    lastB   = '0;
    lastTw  = '0;
    @(negedge clk);
    bStart = 1'b1;
    @(posedge clk);
    #1;
    bStart = 1'b0;
    for (int n = 1; n <= 1200 && doneCyc < 0; n++) begin
      @(negedge clk);
      if (bValid === 1'b1) begin
        vCnt++;
        lastA  = bA;
        lastB  = bB;
        lastTw = bTw;
      end
      if (bDone === 1'b1) doneCyc = n;
      @(posedge clk);
      #1;
    end
    checkValue("big_valid_count", vCnt, 1024);
    checkValue("big_done_cycle", doneCyc, 1057);
    checkValue("big_last_a", lastA, 254);
    checkValue("big_last_b", lastB, 255);
    checkValue("big_last_tw", lastTw, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
